bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the program-counter and operand width (2048-word program space).
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width; opcode = instr[INSTR_W-1 -: 5], operand = instr[ADDR_W-1:0].
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high.
REQ-005 start  in  1  SHALL be a one-cycle-sampled run request; level-sensitive, sampled on clk.
REQ-006 instr  in  INSTR_W  SHALL be the instruction word returned combinationally by program memory for pc_addr.
REQ-007 pc_addr  out  ADDR_W  SHALL be the registered program counter driven to program memory Addr.
REQ-008 operand  out  ADDR_W  SHALL be instr[ADDR_W-1:0] passed through (data address or immediate).
REQ-009 wr_ram, rd_ram, wr_acc  out  1 each  SHALL be data-memory write, data-memory read, accumulator write enables.
REQ-010 sel_a  out  2  SHALL select accumulator source: 00 data memory, 01 immediate, 10 ALU result.
REQ-011 sel_b  out  1  SHALL select ALU operand B: 0 data memory, 1 immediate.
REQ-012 alu_op  out  1  SHALL select ALU function: 0 add, 1 subtract.
REQ-013 busy  out  1  SHALL be 1 exactly while in state RUN; halted  out  1  SHALL be 1 exactly while in state HALT.
REQ-014 cycle_cnt  out  16  SHALL count executed instructions since last run start.

Function
REQ-015 FSM SHALL have states IDLE, RUN, HALT, registered.
REQ-016 IDLE: start=1 -> RUN next cycle, pc_addr=0, cycle_cnt=0; else stay.
REQ-017 RUN: each cycle the instruction at pc_addr SHALL be decoded and its control outputs asserted in the same cycle (zero-latency decode, memory is combinational).
REQ-018 RUN, non-HLT opcode: pc_addr <= pc_addr+1 mod 2^ADDR_W (2047 wraps to 0, no stall); cycle_cnt <= cycle_cnt+1, saturating at 16'hFFFF.
REQ-019 RUN, opcode 00000 (HLT): all enables 0, pc_addr holds, cycle_cnt +1 (saturating), next state HALT.
REQ-020 HALT: pc_addr and cycle_cnt hold; start=1 -> RUN with pc_addr=0, cycle_cnt=0.
REQ-021 start while in RUN SHALL be ignored.
REQ-022 Decode table (only in RUN; all other fields 0): 00001 STO wr_ram=1; 00010 LD rd_ram=1, wr_acc=1, sel_a=00; 00011 LDI wr_acc=1, sel_a=01; 00100 ADD rd_ram=1, wr_acc=1, sel_a=10, sel_b=0, alu_op=0; 00101 ADDI wr_acc=1, sel_a=10, sel_b=1, alu_op=0; 00110 SUB as ADD with alu_op=1; 00111 SUBI as ADDI with alu_op=1.
REQ-023 Opcodes 01000-11111 SHALL execute as NOP: all enables 0, pc advances, counted.
REQ-024 In IDLE and HALT wr_ram, rd_ram, wr_acc SHALL be 0 regardless of instr; sel_a, sel_b, alu_op SHALL be 0.
REQ-025 No two of wr_ram, wr_acc SHALL be 1 in the same cycle.

Reset
REQ-026 reset=1 SHALL immediately (no clock) force state IDLE, pc_addr=0, cycle_cnt=0, busy=0, halted=0, all enables 0.
REQ-027 reset asserted mid-RUN SHALL abort the current instruction; its enables drop in the same delta, no write completes on the next edge.
REQ-028 After reset release, block SHALL stay IDLE until start=1 is sampled.

Verification
REQ-029 Reset, start pulse, program [LDI 5, ADDI 3, STO 7, HLT] -> pc_addr 0,1,2,3 then holds at 3; STO cycle wr_ram=1, operand=7; halted=1; cycle_cnt=4.
REQ-030 SUB at pc 4 with operand 12 -> rd_ram=1, wr_acc=1, sel_a=10, sel_b=0, alu_op=1, operand=12 in that cycle only.
REQ-031 Memory filled with NOP (opcode 01000), run from 0 for 2049 cycles -> pc_addr wraps 2047->0, reads 1 at cycle 2049; no enable ever asserted.
REQ-032 In HALT at pc 3, start=1 -> next cycle busy=1, pc_addr=0, cycle_cnt=0; start held during RUN -> no restart.
REQ-033 Assert reset asynchronously between edges during an STO cycle -> wr_ram falls before next edge, pc_addr=0, state IDLE.
REQ-034 NOP loop for 70000 cycles -> cycle_cnt saturates at 65535 and holds.

Source files
------------

// File: rtl/bip_control.sv
// bip_control -- control unit of a minimal accumulator CPU.
//
// Fetches from a combinational program memory at pc_addr. It decodes the
// returned instruction in the same cycle and drives the datapath enables and
// selects. A small IDLE/RUN/HALT machine sequences execution. cycle_cnt
// counts the instructions executed since the last start.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      run request, sampled in IDLE and HALT
//   instr      instruction word at pc_addr (combinational memory)
//   pc_addr    registered program counter
//   operand    instr[ADDR_W-1:0], data address or immediate
//   wr_ram     data-memory write enable
//   rd_ram     data-memory read enable
//   wr_acc     accumulator write enable
//   sel_a      accumulator source: 00 data memory, 01 immediate, 10 ALU
//   sel_b      ALU operand B: 0 data memory, 1 immediate
//   alu_op     ALU function: 0 add, 1 subtract
//   busy       1 while running
//   halted     1 while halted
//   cycle_cnt  executed-instruction count, saturating
module bip_control #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [ADDR_W-1:0]  operand,
    output logic               wr_ram,
    output logic               rd_ram,
    output logic               wr_acc,
    output logic [1:0]         sel_a,
    output logic               sel_b,
    output logic               alu_op,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [15:0]        cnt_inc;
    logic [4:0]         opcode;

    assign opcode    = instr[INSTR_W-1 -: 5];
    assign operand   = instr[ADDR_W-1:0];
    assign pc_addr   = pc_reg;
    assign cycle_cnt = cnt_reg;
    assign busy      = (state_reg == RUN);
    assign halted    = (state_reg == HALT);
    assign cnt_inc   = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    // Reset acts without a clock. The enables below are decoded from
    // state_reg, so they fall as soon as reset rises and the aborted
    // instruction cannot commit on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state, PC and counter
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                // start is deliberately ignored here
                cnt_next = cnt_inc;
                if (opcode == OP_HLT) begin
                    state_next = HALT;
                end else begin
                    pc_next = pc_reg + ADDR_W'(1);  // wraps at 2^ADDR_W
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Zero-latency decode, active only while running
    always_comb begin
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        wr_acc = 1'b0;
        sel_a  = 2'b00;
        sel_b  = 1'b0;
        alu_op = 1'b0;
        if (state_reg == RUN) begin
            case (opcode)
                OP_STO: wr_ram = 1'b1;
                OP_LD: begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                end
                OP_LDI: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b01;
                end
                OP_ADD, OP_SUB: begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    alu_op = (opcode == OP_SUB);
                end
                OP_ADDI, OP_SUBI: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    sel_b  = 1'b1;
                    alu_op = (opcode == OP_SUBI);
                end
                default: ;  // HLT and the NOP opcodes leave everything at 0
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 16;

    localparam logic [4:0] HLT  = 5'b00000;
    localparam logic [4:0] STO  = 5'b00001;
    localparam logic [4:0] LDI  = 5'b00011;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] SUB  = 5'b00110;
    localparam logic [4:0] NOP  = 5'b01000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_addr;
    logic [ADDR_W-1:0]  operand;
    logic               wr_ram, rd_ram, wr_acc;
    logic [1:0]         sel_a;
    logic               sel_b, alu_op, busy, halted;
    logic [15:0]        cycle_cnt;

    logic [INSTR_W-1:0] mem [0:2047];

    int compared = 0;
    int mismatched = 0;

    assign instr = mem[pc_addr];

    always #5 clk = ~clk;

    bip_control #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .pc_addr(pc_addr), .operand(operand),
        .wr_ram(wr_ram), .rd_ram(rd_ram), .wr_acc(wr_acc),
        .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op),
        .busy(busy), .halted(halted), .cycle_cnt(cycle_cnt)
    );

    function automatic logic [15:0] mk(input logic [4:0] op, input int opnd);
        return {op, 11'(opnd)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {wr_ram, rd_ram, wr_acc, sel_a, sel_b, alu_op}
    function automatic logic [6:0] ctl();
        return {wr_ram, rd_ram, wr_acc, sel_a, sel_b, alu_op};
    endfunction

    // {busy, halted, pc, cnt}
    task automatic check_st(input string tag, input logic b, input logic h,
                            input int pc, input int cnt);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_halted"}, 32'(halted), 32'(h));
        check({tag, "_pc"}, 32'(pc_addr), 32'(pc));
        check({tag, "_cnt"}, 32'(cycle_cnt), 32'(cnt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic any_en;
        for (int i = 0; i < 2048; i++) mem[i] = mk(NOP, 0);
        mem[0] = mk(LDI, 5);
        mem[1] = mk(ADDI, 3);
        mem[2] = mk(STO, 7);
        mem[3] = mk(HLT, 0);

        // Reset state, no clock needed
        #1;
        check_st("reset", 1'b0, 1'b0, 0, 0);
        check("reset_ctl", 32'(ctl()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        check_st("idle_wait", 1'b0, 1'b0, 0, 0);
        check("idle_ctl", 32'(ctl()), 32'h0);

        // Program LDI 5, ADDI 3, STO 7, HLT
        start = 1'b1;
        step();
        start = 1'b0;
        check_st("ldi", 1'b1, 1'b0, 0, 0);
        check("ldi_ctl", 32'(ctl()), 32'(7'b0010100));
        check("ldi_opnd", 32'(operand), 32'd5);
        step();
        check_st("addi", 1'b1, 1'b0, 1, 1);
        check("addi_ctl", 32'(ctl()), 32'(7'b0011010));
        step();
        check_st("sto", 1'b1, 1'b0, 2, 2);
        check("sto_ctl", 32'(ctl()), 32'(7'b1000000));
        check("sto_opnd", 32'(operand), 32'd7);
        step();
        check_st("hlt", 1'b1, 1'b0, 3, 3);
        check("hlt_ctl", 32'(ctl()), 32'h0);
        step();
        check_st("halt", 1'b0, 1'b1, 3, 4);
        check("halt_ctl", 32'(ctl()), 32'h0);
        step();
        check_st("halt_hold", 1'b0, 1'b1, 3, 4);

        // Restart from HALT; start held during RUN is ignored
        start = 1'b1;
        step();
        check_st("restart", 1'b1, 1'b0, 0, 0);
        step();
        check_st("run_start1", 1'b1, 1'b0, 1, 1);
        step();
        check_st("run_start2", 1'b1, 1'b0, 2, 2);
        start = 1'b0;
        step();
        step();
        check_st("halt2", 1'b0, 1'b1, 3, 4);

        // SUB 12 at pc 4 between NOPs
        for (int i = 0; i < 4; i++) mem[i] = mk(NOP, i + 100);
        mem[4] = mk(SUB, 12);
        mem[5] = mk(HLT, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_st("nop3", 1'b1, 1'b0, 3, 3);
        check("nop3_ctl", 32'(ctl()), 32'h0);
        step();
        check_st("sub", 1'b1, 1'b0, 4, 4);
        check("sub_ctl", 32'(ctl()), 32'(7'b0111001));
        check("sub_opnd", 32'(operand), 32'd12);
        step();
        check("after_sub_ctl", 32'(ctl()), 32'h0);
        step();
        check_st("halt3", 1'b0, 1'b1, 5, 6);

        // Asynchronous reset during an STO cycle
        mem[0] = mk(LDI, 1);
        mem[1] = mk(STO, 7);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_rst_wr", 32'(wr_ram), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wr", 32'(wr_ram), 32'd0);
        check("arst_ctl", 32'(ctl()), 32'h0);
        check_st("arst", 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_st("post_rst", 1'b0, 1'b0, 0, 0);

        // All-NOP memory: pc wrap, then counter saturation
        for (int i = 0; i < 2048; i++) mem[i] = mk(NOP, i);
        start = 1'b1;
        step();
        start = 1'b0;
        check_st("nop_run", 1'b1, 1'b0, 0, 0);
        any_en = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            step();
            any_en = any_en | wr_ram | rd_ram | wr_acc;
            if (i == 2047) check("wrap_2047", 32'(pc_addr), 32'd2047);
            if (i == 2048) check("wrap_2048", 32'(pc_addr), 32'd0);
            if (i == 2049) begin
                check("wrap_2049", 32'(pc_addr), 32'd1);
                check("cnt_2049", 32'(cycle_cnt), 32'd2049);
                check("nop_no_en", 32'(any_en), 32'd0);
            end
            if (i == 65534) check("cnt_65534", 32'(cycle_cnt), 32'd65534);
            if (i == 65535) check("cnt_65535", 32'(cycle_cnt), 32'd65535);
        end
        check("sat_hold", 32'(cycle_cnt), 32'd65535);
        check("sat_pc", 32'(pc_addr), 32'd368);
        check("sat_busy", 32'(busy), 32'd1);
        check("loop_no_en", 32'(any_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
